// File: rtl/spi_reg_sequencer.sv
// spi_reg_sequencer: command/register sequencer behind a Mode-3 SPI byte slave.
// The first byte of each SS frame selects read/write and a start address.
// Following bytes become burst writes, or drive prefetched burst reads.
//
// Ports:
//   sysClk, nReset   clock; synchronous active-low reset
//   ssActive         synchronized slave-select (1 = frame open)
//   rx, rxValid      received byte and its one-cycle strobe
//   tx               next byte for the byte slave to shift out
//   statusIn         byte returned while the command byte shifts
//   regAddr          register address
//   regWrEn          one-cycle write strobe
//   regWrData        write data
//   regRdEn          one-cycle read strobe
//   regRdData        read data, RD_LAT cycles after regRdEn
//   busy             frame open
//   frameDone        pulse at the end of a frame that carried bytes
//
// Build option:
//   SPI_REG_SEQ_AUTOINC_EN  defined: regAddr steps once per data byte.
//                           undefined: regAddr holds the command address.

module spi_reg_sequencer #(
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic              sysClk,
  input  logic              nReset,
  input  logic              ssActive,
  input  logic [7:0]        rx,
  input  logic              rxValid,
  output logic [7:0]        tx,
  input  logic [7:0]        statusIn,
  output logic [ADDR_W-1:0] regAddr,
  output logic              regWrEn,
  output logic [7:0]        regWrData,
  output logic              regRdEn,
  input  logic [7:0]        regRdData,
  output logic              busy,
  output logic              frameDone
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WR,
    S_RD
  } state_t;

  state_t              r_state;
  logic                r_ssPrev;
  logic                r_gotByte;
  logic [RD_LAT-1:0]   r_rdPipe;

  logic                w_rxv;
  logic                w_ssRise;
  logic                w_rdDone;
  logic [ADDR_W-1:0]   w_addrNext;

  // A byte counts only while the frame is still open.
  assign w_rxv    = rxValid & ssActive;
  assign w_ssRise = ssActive & ~r_ssPrev;
  // Tracks each regRdEn; the top bit marks regRdData valid.
  assign w_rdDone = r_rdPipe[RD_LAT-1];

`ifdef SPI_REG_SEQ_AUTOINC_EN
  assign w_addrNext = regAddr + ADDR_W'(1);
`else
  assign w_addrNext = regAddr;
`endif

  always_ff @(posedge sysClk) begin
    if (!nReset) begin
      r_state   <= S_IDLE;
      r_ssPrev  <= 1'b0;
      r_gotByte <= 1'b0;
      r_rdPipe  <= '0;
      tx        <= 8'h00;
      regAddr   <= '0;
      regWrData <= 8'h00;
      regWrEn   <= 1'b0;
      regRdEn   <= 1'b0;
      busy      <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      r_ssPrev  <= ssActive;
      regWrEn   <= 1'b0;
      regRdEn   <= 1'b0;
      frameDone <= 1'b0;
      r_rdPipe  <= (r_rdPipe << 1) | RD_LAT'(regRdEn);

      // Step past the address just written; a new command overrides.
      if (regWrEn) begin
        regAddr <= w_addrNext;
      end

      if (r_state != S_IDLE && !ssActive) begin
        // Frame closed: drop reads still in flight.
        r_state   <= S_IDLE;
        busy      <= 1'b0;
        frameDone <= r_gotByte;
        r_rdPipe  <= '0;
        tx        <= statusIn;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            tx <= statusIn;
            if (w_ssRise) begin
              r_state   <= S_CMD;
              busy      <= 1'b1;
              r_gotByte <= 1'b0;
            end
          end
          S_CMD: begin
            tx <= statusIn;
            if (w_rxv) begin
              r_gotByte <= 1'b1;
              regAddr   <= rx[ADDR_W-1:0];
              if (rx[7]) begin
                r_state <= S_RD;
                regRdEn <= 1'b1;
              end else begin
                r_state <= S_WR;
                tx      <= 8'h00;
              end
            end
          end
          S_WR: begin
            tx <= 8'h00;
            if (w_rxv) begin
              r_gotByte <= 1'b1;
              regWrData <= rx;
              regWrEn   <= 1'b1;
            end
          end
          S_RD: begin
            // Prefetch: data fetched for byte k shifts out in byte k+1.
            if (w_rdDone) begin
              tx <= regRdData;
            end
            if (w_rxv) begin
              r_gotByte <= 1'b1;
              regAddr   <= w_addrNext;
              regRdEn   <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
